// File: rtl/pong_game_ctrl_pkg.sv
// Shared pong defines: table/paddle geometry, game-state encoding and serve constants.
// The overlay renderer imports this too, so it decodes the state bus the same way.
package pong_game_ctrl_pkg;

    localparam int unsigned TABLE_W    = 640;
    localparam int unsigned TABLE_H    = 480;
    localparam int unsigned PADDLE_W   = 8;
    localparam int unsigned PADDLE_H   = 64;
    localparam int unsigned PADDLE_GAP = 16;
    localparam int unsigned BALL_SIZE  = 8;

    localparam int unsigned WIN_SCORE_DEFAULT = 9;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StServe  = 3'd1,
        StPlay   = 3'd2,
        StScored = 3'd3,
        StOver   = 3'd4
    } game_state_e;

    // Opposing requests cancel so a paddle never sees up and down together.
    function automatic logic [1:0] paddle_gate(input logic up, input logic down,
                                               input logic en);
        return {up & ~down & en, down & ~up & en};
    endfunction

endpackage

// File: rtl/pong_edge_det.sv
// Rising-edge pulse generator: registers the level once and flags a 0->1 transition.
module pong_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic pulse
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign pulse = sig & ~sig_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: gates paddle requests, serves the ball and keeps score,
// stepping through attract, serve, play, scored and game-over phases in frames.
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int unsigned WIN_SCORE     = WIN_SCORE_DEFAULT,
    parameter int unsigned SERVE_FRAMES  = 60,
    parameter int unsigned SCORED_FRAMES = 90
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vblank,
    input  logic       start_btn,
    input  logic       up_l_in,
    input  logic       down_l_in,
    input  logic       up_r_in,
    input  logic       down_r_in,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       up_l,
    output logic       down_l,
    output logic       up_r,
    output logic       down_r,
    output logic       ball_en,
    output logic       ball_serve,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [2:0] state,
    output logic       winner
);

    localparam logic [3:0] WinScore     = 4'(WIN_SCORE);
    localparam logic [7:0] ServeFrames  = 8'(SERVE_FRAMES);
    localparam logic [7:0] ScoredFrames = 8'(SCORED_FRAMES);

    logic        frame_tick;
    logic        start_pulse;
    logic        paddle_en;
    logic [7:0]  frame_cnt_q;
    logic [3:0]  score_l_inc;
    logic [3:0]  score_r_inc;
    logic [1:0]  gate_l;
    logic [1:0]  gate_r;
    game_state_e state_q;

    pong_edge_det u_vblank_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (vblank),
        .pulse (frame_tick)
    );

    pong_edge_det u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (start_btn),
        .pulse (start_pulse)
    );

    assign paddle_en   = (state_q == StServe) || (state_q == StPlay);
    assign gate_l      = paddle_gate(up_l_in, down_l_in, paddle_en);
    assign gate_r      = paddle_gate(up_r_in, down_r_in, paddle_en);
    assign score_l_inc = score_l + 4'd1;
    assign score_r_inc = score_r + 4'd1;
    assign state       = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            frame_cnt_q <= 8'd0;
            up_l        <= 1'b0;
            down_l      <= 1'b0;
            up_r        <= 1'b0;
            down_r      <= 1'b0;
            ball_en     <= 1'b0;
            ball_serve  <= 1'b0;
            serve_dir   <= 1'b0;
            score_l     <= 4'd0;
            score_r     <= 4'd0;
            winner      <= 1'b0;
        end else begin
            {up_l, down_l} <= gate_l;
            {up_r, down_r} <= gate_r;
            ball_serve     <= 1'b0;

            if (frame_tick) begin
                frame_cnt_q <= frame_cnt_q - 8'd1;
            end

            unique case (state_q)
                StIdle, StOver: begin
                    ball_en <= 1'b0;
                    if (start_pulse) begin
                        score_l     <= 4'd0;
                        score_r     <= 4'd0;
                        serve_dir   <= SERVE_RIGHT;
                        winner      <= 1'b0;
                        frame_cnt_q <= ServeFrames;
                        state_q     <= StServe;
                    end
                end
                StServe: begin
                    ball_en <= 1'b0;
                    if (frame_tick && frame_cnt_q == 8'd1) begin
                        ball_serve <= 1'b1;
                        state_q    <= StPlay;
                    end
                end
                StPlay: begin
                    // Ball starts moving the cycle after the serve pulse.
                    ball_en <= 1'b1;
                    if (miss_l && miss_r) begin
                        ball_en     <= 1'b0;
                        frame_cnt_q <= ScoredFrames;
                        state_q     <= StScored;
                    end else if (miss_l) begin
                        ball_en   <= 1'b0;
                        score_r   <= score_r_inc;
                        serve_dir <= SERVE_LEFT;
                        if (score_r_inc == WinScore) begin
                            winner  <= 1'b1;
                            state_q <= StOver;
                        end else begin
                            frame_cnt_q <= ScoredFrames;
                            state_q     <= StScored;
                        end
                    end else if (miss_r) begin
                        ball_en   <= 1'b0;
                        score_l   <= score_l_inc;
                        serve_dir <= SERVE_RIGHT;
                        if (score_l_inc == WinScore) begin
                            winner  <= 1'b0;
                            state_q <= StOver;
                        end else begin
                            frame_cnt_q <= ScoredFrames;
                            state_q     <= StScored;
                        end
                    end
                end
                StScored: begin
                    ball_en <= 1'b0;
                    if (frame_tick && frame_cnt_q == 8'd1) begin
                        frame_cnt_q <= ServeFrames;
                        state_q     <= StServe;
                    end
                end
                default: begin
                    ball_en <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized and scenario-driven bench for pong_game_ctrl against a phase-level match model.
module tb_pong_game_ctrl;

    localparam int WIN    = 3;
    localparam int SERVE  = 2;
    localparam int SCORED = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vblank, start_btn, up_l_in, down_l_in, up_r_in, down_r_in, miss_l, miss_r;
    logic       up_l, down_l, up_r, down_r, ball_en, ball_serve, serve_dir, winner;
    logic [3:0] score_l, score_r;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: match phase (0 idle,1 serve,2 play,3 scored,4 over) and frames left.
    int   m_phase, m_left, m_sl, m_sr;
    logic m_dir, m_win, m_ball_en, m_serve, m_vb, m_sb;
    logic [3:0] m_pad;

    pong_game_ctrl #(
        .WIN_SCORE     (WIN),
        .SERVE_FRAMES  (SERVE),
        .SCORED_FRAMES (SCORED)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vblank     (vblank),
        .start_btn  (start_btn),
        .up_l_in    (up_l_in),
        .down_l_in  (down_l_in),
        .up_r_in    (up_r_in),
        .down_r_in  (down_r_in),
        .miss_l     (miss_l),
        .miss_r     (miss_r),
        .up_l       (up_l),
        .down_l     (down_l),
        .up_r       (up_r),
        .down_r     (down_r),
        .ball_en    (ball_en),
        .ball_serve (ball_serve),
        .serve_dir  (serve_dir),
        .score_l    (score_l),
        .score_r    (score_r),
        .state      (state),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_sl = 0; m_sr = 0;
        m_dir = 0; m_win = 0; m_ball_en = 0; m_serve = 0; m_vb = 0; m_sb = 0;
        m_pad = 4'b0000;
    endtask

    // Advance the match model by one clock with the currently applied inputs.
    task automatic model_step();
        logic tick, sp, live;
        tick = vblank && !m_vb;
        sp   = start_btn && !m_sb;
        m_vb = vblank;
        m_sb = start_btn;
        live = (m_phase == 1 || m_phase == 2);
        m_pad = {up_l_in && !down_l_in && live, down_l_in && !up_l_in && live,
                 up_r_in && !down_r_in && live, down_r_in && !up_r_in && live};
        m_serve = 1'b0;
        case (m_phase)
            0, 4: if (sp) begin
                m_sl = 0; m_sr = 0; m_dir = 1; m_win = 0; m_phase = 1; m_left = SERVE;
            end
            1: if (tick) begin
                if (m_left == 1) begin
                    m_phase = 2; m_serve = 1'b1;
                end else begin
                    m_left--;
                end
            end
            2: if (miss_l && miss_r) begin
                m_phase = 3; m_left = SCORED;
            end else if (miss_l || miss_r) begin
                if (miss_l) begin m_sr++; m_dir = 0; end
                else begin m_sl++; m_dir = 1; end
                if (m_sl == WIN || m_sr == WIN) begin
                    m_phase = 4; m_win = (m_sr == WIN);
                end else begin
                    m_phase = 3; m_left = SCORED;
                end
            end
            3: if (tick) begin
                if (m_left == 1) begin m_phase = 1; m_left = SERVE; end
                else m_left--;
            end
            default: ;
        endcase
        m_ball_en = (m_phase == 2) && !m_serve;
    endtask

    task automatic compare_all();
        check_eq("state", 32'(state), 32'(m_phase));
        check_eq("score_l", 32'(score_l), 32'(m_sl));
        check_eq("score_r", 32'(score_r), 32'(m_sr));
        check_eq("serve_dir", 32'(serve_dir), 32'(m_dir));
        check_eq("winner", 32'(winner), 32'(m_win));
        check_eq("ball_en", 32'(ball_en), 32'(m_ball_en));
        check_eq("ball_serve", 32'(ball_serve), 32'(m_serve));
        check_eq("paddles", 32'({up_l, down_l, up_r, down_r}), 32'(m_pad));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vblank = 1'b1; step();
            vblank = 1'b0; step();
        end
    endtask

    task automatic miss(input logic l, input logic r);
        miss_l = l; miss_r = r; step();
        miss_l = 1'b0; miss_r = 1'b0;
    endtask

    // Asserts reset between edges and checks outputs clear without any clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_outs", 32'({up_l, down_l, up_r, down_r, ball_en, ball_serve, serve_dir,
                                  winner, score_l, score_r}), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        {vblank, start_btn, up_l_in, down_l_in, up_r_in, down_r_in, miss_l, miss_r} = '0;
        model_reset();
        #12;
        check_eq("reset_state", 32'(state), 32'd0);
        check_eq("reset_scores", 32'({score_l, score_r}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start, then two frame rises to the serve.
        start_btn = 1'b1; step();
        check_eq("t1_serve_state", 32'(state), 32'd1);
        start_btn = 1'b0;
        vblank = 1'b1; step();
        vblank = 1'b0; step();
        vblank = 1'b1; step();
        check_eq("t1_ball_serve", 32'(ball_serve), 32'd1);
        check_eq("t1_play_state", 32'(state), 32'd2);
        vblank = 1'b0; step();
        check_eq("t1_serve_gone", 32'(ball_serve), 32'd0);
        check_eq("t1_ball_en", 32'(ball_en), 32'd1);
        check_eq("t1_serve_dir", 32'(serve_dir), 32'd1);

        // Held miss_l scores once.
        miss_l = 1'b1;
        for (int i = 0; i < 5; i++) step();
        miss_l = 1'b0;
        check_eq("t2_score_r", 32'(score_r), 32'd1);
        check_eq("t2_dir", 32'(serve_dir), 32'd0);
        check_eq("t2_scored", 32'(state), 32'd3);
        frames(3);
        check_eq("t2_back_serve", 32'(state), 32'd1);

        // Simultaneous misses: no score, direction kept.
        frames(SERVE);
        miss(1'b1, 1'b1);
        check_eq("t4_scores", 32'({score_l, score_r}), 32'h01);
        check_eq("t4_dir", 32'(serve_dir), 32'd0);
        check_eq("t4_state", 32'(state), 32'd3);
        frames(SCORED);

        // Left wins with three points.
        for (int i = 0; i < WIN; i++) begin
            frames(SERVE);
            miss(1'b0, 1'b1);
            if (i < WIN - 1) frames(SCORED);
        end
        check_eq("t3_score_l", 32'(score_l), 32'd3);
        check_eq("t3_over", 32'(state), 32'd4);
        check_eq("t3_winner", 32'(winner), 32'd0);
        frames(4);
        check_eq("t3_held", 32'(score_l), 32'd3);
        start_btn = 1'b1; step();
        start_btn = 1'b0;
        check_eq("t3_restart", 32'({score_l, score_r}), 32'h00);
        check_eq("t3_restart_state", 32'(state), 32'd1);

        // Paddle gating.
        async_reset();
        up_l_in = 1'b1; step();
        check_eq("t5_idle_up", 32'(up_l), 32'd0);
        start_btn = 1'b1; step();
        start_btn = 1'b0;
        step();
        check_eq("t5_serve_up", 32'(up_l), 32'd1);
        down_l_in = 1'b1; step();
        check_eq("t5_both", 32'({up_l, down_l}), 32'd0);
        up_l_in = 1'b0; down_l_in = 1'b0;

        // Reach PLAY at 2:1 then reset asynchronously.
        frames(SERVE); miss(1'b0, 1'b1); frames(SCORED);
        frames(SERVE); miss(1'b0, 1'b1); frames(SCORED);
        frames(SERVE); miss(1'b1, 1'b0); frames(SCORED);
        frames(SERVE);
        check_eq("t6_score", 32'({score_l, score_r}), 32'h21);
        check_eq("t6_play", 32'(state), 32'd2);
        async_reset();

        // Random play against the model.
        for (int i = 0; i < 4000; i++) begin
            vblank    = 1'($urandom_range(0, 1));
            start_btn = ($urandom_range(0, 19) == 0);
            up_l_in   = 1'($urandom_range(0, 1));
            down_l_in = 1'($urandom_range(0, 1));
            up_r_in   = 1'($urandom_range(0, 1));
            down_r_in = 1'($urandom_range(0, 1));
            miss_l    = ($urandom_range(0, 9) == 0);
            miss_r    = ($urandom_range(0, 9) == 0);
            step();
            if ($urandom_range(0, 999) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level game sequencer for the pong design. It gates the players' up/down requests into both paddle instances, arms and serves the ball, and keeps the score. It advances a match through attract, serve, play, point-scored and game-over phases, timed in frames by the vblank signal.

Parameters:
WIN_SCORE, 9, points needed to win; legal range 1..15.
SERVE_FRAMES, 60, frames spent in SERVE before the ball launches; legal range 1..255.
SCORED_FRAMES, 90, frames spent in SCORED after a point; legal range 1..255.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vblank  in  1  vertical blank level from the VGA timing block, synchronous to clk
start_btn  in  1  start button, already debounced, level
up_l_in  in  1  left player up request
down_l_in  in  1  left player down request
up_r_in  in  1  right player up request
down_r_in  in  1  right player down request
miss_l  in  1  ball passed the left goal line (point to right); level or pulse
miss_r  in  1  ball passed the right goal line (point to left); level or pulse
up_l, down_l, up_r, down_r  out  1 each  gated requests driven to the paddle instances
ball_en  out  1  ball may move and is drawn
ball_serve  out  1  one-cycle pulse: ball reloads to centre and launches
serve_dir  out  1  launch direction; 1 = toward right, 0 = toward left
score_l, score_r  out  4 each  current scores
state  out  3  current FSM state, for debug and the overlay renderer
winner  out  1  valid in OVER only; 0 = left, 1 = right

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; every output is 0; frame counter=0; edge-detect registers=0.
- Edge detection:
  - vblank and start_btn are registered once.
  - frame_tick = vblank & ~vblank_q.
  - start_pulse = start_btn & ~start_q.
  - Each is a one-cycle pulse.
- Frame counter:
  - 8-bit down counter, loaded with N on entry to SERVE or SCORED.
  - Decrements on each frame_tick.
  - The state exits on the frame_tick where the counter equals 1, so the state lasts exactly N frame_ticks.
- IDLE:
  - Paddles and ball disabled.
  - start_pulse: scores cleared to 0, serve_dir <= 1, go to SERVE.
- SERVE:
  - Paddles enabled, ball_en=0.
  - On counter expiry: go to PLAY, ball_serve=1 for exactly that one cycle, ball_en=1 from the next cycle.
- PLAY:
  - Paddles and ball enabled.
  - miss_l only: score_r += 1, serve_dir <= 0 (serve toward the loser).
  - miss_r only: score_l += 1, serve_dir <= 1.
  - After the increment: if the new score equals WIN_SCORE, go to OVER and set winner. Otherwise go to SCORED.
  - miss_l and miss_r in the same cycle: no score change, serve_dir unchanged, go to SCORED.
  - Miss inputs are sampled only in PLAY. A held level therefore scores exactly once.
- SCORED:
  - Paddles and ball disabled.
  - On counter expiry: go to SERVE.
- OVER:
  - Paddles and ball disabled. Scores and winner held.
  - start_pulse: scores cleared, serve_dir <= 1, go to SERVE.
- Paddle gating (registered, 1-cycle latency):
  - up_x = up_x_in & ~down_x_in & paddle_en.
  - down_x = down_x_in & ~up_x_in & paddle_en.
  - Both pressed: both outputs 0.
  - paddle_en = (state==SERVE | state==PLAY).
- Scores:
  - Never exceed WIN_SCORE.
  - Increment uses 4-bit arithmetic. No wrap is possible within the legal parameter range.
- start_pulse in SERVE, PLAY or SCORED is ignored.
- Reset asserted mid-match returns the block to IDLE asynchronously, with all outputs 0.
- state encoding: IDLE=0, SERVE=1, PLAY=2, SCORED=3, OVER=4.

Decomposition:
- Shared defines file holds:
  - state encodings;
  - the WIN_SCORE default;
  - serve-direction constants.
- These sit alongside the existing table and paddle geometry defines, so the overlay renderer decodes state identically.
- One natural sub-module, pong_edge_det: a registered rising-edge pulse generator with asynchronous active-low reset, instanced for vblank and for start_btn.
- The FSM, frame counter and scoring stay in pong_game_ctrl.

Test Plan:
(All scenarios use WIN_SCORE=3, SERVE_FRAMES=2, SCORED_FRAMES=3.)
1. Reset, then one start_btn press -> state 0→1. Exactly 2 vblank rises later, ball_serve is high for 1 cycle, state=2, ball_en=1, serve_dir=1.
2. In PLAY, hold miss_l for 5 cycles -> score_r=1 (once only), serve_dir=0, state=3. After 3 vblank rises, state=1.
3. Drive miss_r three times through successive SERVE/PLAY cycles -> score_l=3, state=4, winner=0. A later start_btn press gives scores 0/0 and state=1.
4. miss_l and miss_r in the same cycle during PLAY -> both scores unchanged, serve_dir unchanged, state=3.
5. up_l_in=1 in IDLE -> up_l=0. In SERVE -> up_l=1 one cycle after the input. up_l_in and down_l_in both 1 -> up_l=0, down_l=0.
6. Assert rst_n=0 mid-PLAY with score 2:1 -> state=0 immediately, scores 0, all outputs 0, with no clock edge required.
